// File: rtl/button_event_gen.sv
// button_event_gen
//   Turns the four debounced button levels into press and auto-repeat events.
//   Each button owns a one-deep pending slot; a fixed-priority arbiter feeds a
//   single registered valid/ready event port. A one-cycle strobe per button
//   reports every fresh press independently of the event handshake.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active low
//   left/right/middle/down  debounced levels, asynchronous to clk
//   repeat_en            auto-repeat enable, synchronous to clk
//   evt_valid/evt_ready  event handshake
//   evt_code             0=left 1=right 2=middle 3=down
//   evt_repeat           1 = auto-repeat event, 0 = fresh press
//   pulse_l/r/m/d        one-cycle press strobes
//   drop_cnt             saturating count of events lost to a full slot
module button_event_gen #(
  parameter int CNT_W         = 26,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  input  logic       down,
  input  logic       repeat_en,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_repeat,
  input  logic       evt_ready,
  output logic       pulse_l,
  output logic       pulse_r,
  output logic       pulse_m,
  output logic       pulse_d,
  output logic [7:0] drop_cnt
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // Bit index equals the event code: 0=left 1=right 2=middle 3=down.
  logic [3:0] btn_raw;
  assign btn_raw = {down, middle, right, left};

  // Synchronizer: sync_p0/sync_p1 are the two metastability flops,
  // sync_p2 holds the previous synchronized level for edge detection.
  logic [3:0] sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge detection and hold counter (operate on sync_p1 / sync_p2).
  logic [3:0]       press;
  logic             one_held;
  logic             hold_run;
  logic             rpt_hit;
  logic [3:0]       rpt_vec;
  logic [CNT_W-1:0] hold_cnt;
  logic             phase;

  assign press    = sync_p1 & ~sync_p2;
  assign one_held = (sync_p1 != 4'd0) && ((sync_p1 & (sync_p1 - 4'd1)) == 4'd0);
  // A change of the held set shows up as sync_p1 != sync_p2 and restarts timing.
  assign hold_run = repeat_en && one_held && (sync_p1 == sync_p2);
  assign rpt_hit  = hold_run && (hold_cnt == (phase ? PERIOD_LAST : DELAY_LAST));
  assign rpt_vec  = rpt_hit ? sync_p1 : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      phase    <= 1'b0;
    end else if (!hold_run) begin
      hold_cnt <= '0;
      phase    <= 1'b0;
    end else if (rpt_hit) begin
      hold_cnt <= '0;
      phase    <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Pending slots and arbiter.
  logic [3:0] pend_v, pend_r;
  logic [3:0] new_evt;
  logic [3:0] grant;
  logic [3:0] drops;
  logic [1:0] grant_code;
  logic       grant_any;
  logic       take;
  logic [2:0] drop_num;
  logic [8:0] drop_sum;

  assign new_evt   = press | rpt_vec;
  // Output register is empty or is handing its event over on this edge.
  assign take      = !evt_valid || evt_ready;
  assign grant_any = |grant;

  always_comb begin
    grant      = 4'd0;
    grant_code = 2'd0;
    if (take) begin
      if (pend_v[2]) begin
        grant[2]   = 1'b1;
        grant_code = 2'd2;
      end else if (pend_v[0]) begin
        grant[0]   = 1'b1;
        grant_code = 2'd0;
      end else if (pend_v[1]) begin
        grant[1]   = 1'b1;
        grant_code = 2'd1;
      end else if (pend_v[3]) begin
        grant[3]   = 1'b1;
        grant_code = 2'd3;
      end
    end
  end

  always_comb begin
    drops    = 4'd0;
    drop_num = 3'd0;
    for (int b = 0; b < 4; b++) begin
      // A slot being granted this cycle counts as free, so it reloads without a drop.
      drops[b] = new_evt[b] && pend_v[b] && !grant[b];
      drop_num = drop_num + 3'(drops[b]);
    end
    drop_sum = {1'b0, drop_cnt} + 9'(drop_num);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v   <= '0;
      pend_r   <= '0;
      drop_cnt <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (new_evt[b] && (!pend_v[b] || grant[b])) begin
          pend_v[b] <= 1'b1;
          pend_r[b] <= rpt_vec[b];
        end else if (grant[b]) begin
          pend_v[b] <= 1'b0;
        end
      end
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Output register and press strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid  <= 1'b0;
      evt_code   <= 2'd0;
      evt_repeat <= 1'b0;
      pulse_l    <= 1'b0;
      pulse_r    <= 1'b0;
      pulse_m    <= 1'b0;
      pulse_d    <= 1'b0;
    end else begin
      if (grant_any) begin
        evt_valid  <= 1'b1;
        evt_code   <= grant_code;
        evt_repeat <= pend_r[grant_code];
      end else if (evt_valid && evt_ready) begin
        evt_valid  <= 1'b0;
      end
      pulse_l <= press[0];
      pulse_r <= press[1];
      pulse_m <= press[2];
      pulse_d <= press[3];
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen
//   Directed test-plan sequences followed by a randomized phase, all compared
//   cycle by cycle against a behavioural model of the event generator.
module tb_button_event_gen;

  localparam int DLY = 10;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       left, right, middle, down;
  logic       repeat_en;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_repeat;
  logic       pulse_l, pulse_r, pulse_m, pulse_d;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_gen #(
    .CNT_W(8),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .left(left),
    .right(right),
    .middle(middle),
    .down(down),
    .repeat_en(repeat_en),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_repeat(evt_repeat),
    .evt_ready(evt_ready),
    .pulse_l(pulse_l),
    .pulse_r(pulse_r),
    .pulse_m(pulse_m),
    .pulse_d(pulse_d),
    .drop_cnt(drop_cnt)
  );

  // Behavioural model state
  logic [3:0] hist [0:2];   // button levels seen at the last three edges, [0] newest
  int         run;          // consecutive edges with one stable button held and repeat on
  bit         mv [4];
  bit         mr [4];
  bit         m_valid;
  int         m_code;
  bit         m_rep;
  logic [3:0] m_pulse;
  int         m_drop;
  int         prio [4] = '{2, 0, 1, 3};

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 4'd0;
    run = 0;
    for (int b = 0; b < 4; b++) begin
      mv[b] = 1'b0;
      mr[b] = 1'b0;
    end
    m_valid = 1'b0;
    m_code  = 0;
    m_rep   = 1'b0;
    m_pulse = 4'd0;
    m_drop  = 0;
  endtask

  task automatic model_edge();
    logic [3:0] cur, prev, press, rpt;
    int g;
    cur   = hist[1];
    prev  = hist[2];
    press = cur & ~prev;
    if (repeat_en && $countones(cur) == 1 && cur == prev) run++;
    else run = 0;
    rpt = (run == DLY || (run > DLY && (run - DLY) % PER == 0)) ? cur : 4'd0;
    g = -1;
    if (!m_valid || evt_ready) begin
      for (int i = 0; i < 4; i++)
        if (g < 0 && mv[prio[i]]) g = prio[i];
    end
    if (g >= 0) begin
      m_valid = 1'b1;
      m_code  = g;
      m_rep   = mr[g];
      mv[g]   = 1'b0;
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      if (press[b] || rpt[b]) begin
        if (!mv[b]) begin
          mv[b] = 1'b1;
          mr[b] = rpt[b];
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    m_pulse = press;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {down, middle, right, left};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("evt_code", 32'(evt_code), 32'(m_code));
      chk("evt_repeat", 32'(evt_repeat), 32'(m_rep));
    end
    chk("pulses", 32'({pulse_d, pulse_m, pulse_r, pulse_l}), 32'(m_pulse));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_code"}, 32'(evt_code), 32'd0);
    chk({tag, "_repeat"}, 32'(evt_repeat), 32'd0);
    chk({tag, "_pulses"}, 32'({pulse_d, pulse_m, pulse_r, pulse_l}), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    rst = 1'b0;
    {left, right, middle, down} = 4'd0;
    repeat_en = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step(2);

    // Single left press, consumer always ready
    evt_ready = 1'b1;
    left = 1'b1;
    step(20);
    left = 1'b0;
    step(6);

    // middle and down together: emitted in priority order
    middle = 1'b1;
    down   = 1'b1;
    step(8);
    middle = 1'b0;
    down   = 1'b0;
    step(6);

    // Held right with auto-repeat
    repeat_en = 1'b1;
    right = 1'b1;
    step(30);
    right = 1'b0;
    step(10);

    // Held left with a stalled consumer: slot fills, later repeats drop
    evt_ready = 1'b0;
    left = 1'b1;
    step(40);
    evt_ready = 1'b1;
    left = 1'b0;
    step(10);

    // Two buttons held: no repeats; release one restarts timing for the other
    left  = 1'b1;
    right = 1'b1;
    step(30);
    right = 1'b0;
    step(20);
    left = 1'b0;
    step(5);

    // Long stalled hold drives drop_cnt into saturation
    evt_ready = 1'b0;
    down = 1'b1;
    step(1100);
    down = 1'b0;
    evt_ready = 1'b1;
    step(8);

    // Asynchronous reset mid-repeat with an event waiting
    evt_ready = 1'b0;
    left = 1'b1;
    step(20);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    left = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    evt_ready = 1'b1;
    step(10);

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) left   = ~left;
      if ($urandom_range(0, 11) == 0) right  = ~right;
      if ($urandom_range(0, 11) == 0) middle = ~middle;
      if ($urandom_range(0, 11) == 0) down   = ~down;
      if ($urandom_range(0, 99) == 0) repeat_en = ~repeat_en;
      evt_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
